// File: rtl/teclado_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, idle row
// pattern and the bounce LFSR polynomial.
package teclado_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BOUNCE_IN  = 3'd1,
    ST_HOLD       = 3'd2,
    ST_BOUNCE_OUT = 3'd3,
    ST_GAP        = 3'd4
  } emu_state_t;

  localparam logic [3:0]  FIL_IDLE  = 4'b1111;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/teclado_emulador_if.sv
// Press-command channel between a key-sequence source and the keypad emulator.
interface teclado_emulador_if #(parameter int unsigned HOLD_W = 25);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_row;
  logic [1:0]        cmd_col;
  logic [HOLD_W-1:0] cmd_hold;
  logic              cmd_abort;

  modport master (output cmd_valid, cmd_row, cmd_col, cmd_hold, cmd_abort,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_row, cmd_col, cmd_hold, cmd_abort,
                  output cmd_ready);
endinterface

// File: rtl/teclado_emulador_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only reset reloads it, so a nonzero
// seed keeps it off the all-zero lockup state.
module lfsr16
  import teclado_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= SEED;
    else      q <= lfsr_next(q);
  end

endmodule

// File: rtl/teclado_emulador.sv
// Passive 4x4 membrane keypad model: closes one row/column contact per command,
// with LFSR-driven contact bounce on press and release.
module teclado_emulador
  import teclado_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 270_000,
  parameter int unsigned BOUNCE_STEP   = 2_700,
  parameter int unsigned RELEASE_GAP   = 27_000,
  parameter int unsigned HOLD_W        = 25,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  teclado_emulador_if.slave cmd,
  input  logic [3:0]        col,
  output logic [3:0]        fil,
  output logic              busy,
  output logic              done
);

  localparam int BW = (BOUNCE_CYCLES > 2) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int SW = (BOUNCE_STEP   > 2) ? $clog2(BOUNCE_STEP)   : 1;
  localparam int GW = (RELEASE_GAP   > 2) ? $clog2(RELEASE_GAP)   : 1;
  localparam int CW = (int'(HOLD_W) > GW) ? int'(HOLD_W) : GW;

  localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);
  localparam bit NO_GAP    = (RELEASE_GAP == 0);

  // Counters are loaded with length-1 and the state exits when they read 0.
  localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(BOUNCE_STEP - 1);
  localparam logic [CW-1:0] G_LAST = CW'(RELEASE_GAP - 1);

  emu_state_t        state_q, state_d;
  logic              contact_q, contact_d;
  logic [1:0]        key_row_q, key_row_d;
  logic [1:0]        key_col_q, key_col_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [BW-1:0]     bnc_q, bnc_d;
  logic [SW-1:0]     stp_q, stp_d;
  logic [CW-1:0]     hg_q, hg_d;
  logic              busy_q, done_q, done_d;
  logic              release_now;
  logic [HOLD_W-1:0] hold_eff;
  logic [15:0]       lfsr;
  logic              unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:1];
  assign hold_eff    = (cmd.cmd_hold == '0) ? HOLD_W'(1) : cmd.cmd_hold;

  always_comb begin
    state_d     = state_q;
    contact_d   = contact_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    hold_d      = hold_q;
    bnc_d       = bnc_q;
    stp_d       = stp_q;
    hg_d        = hg_q;
    done_d      = 1'b0;
    release_now = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          key_row_d = cmd.cmd_row;
          key_col_d = cmd.cmd_col;
          hold_d    = hold_eff;
          if (NO_BOUNCE) begin
            state_d   = ST_HOLD;
            contact_d = 1'b1;
            hg_d      = CW'(hold_eff) - CW'(1);
          end else begin
            state_d   = ST_BOUNCE_IN;
            contact_d = lfsr[0];
            bnc_d     = B_LAST;
            stp_d     = S_LAST;
          end
        end
      end

      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (cmd.cmd_abort) begin
          release_now = 1'b1;
        end else if (bnc_q == '0) begin
          if (state_q == ST_BOUNCE_IN) begin
            state_d   = ST_HOLD;
            contact_d = 1'b1;
            hg_d      = CW'(hold_q) - CW'(1);
          end else begin
            release_now = 1'b1;
          end
        end else begin
          bnc_d = bnc_q - BW'(1);
          if (stp_q == '0) begin
            contact_d = lfsr[0];
            stp_d     = S_LAST;
          end else begin
            stp_d = stp_q - SW'(1);
          end
        end
      end

      ST_HOLD: begin
        if (cmd.cmd_abort || (hg_q == '0 && NO_BOUNCE)) begin
          release_now = 1'b1;
        end else if (hg_q == '0) begin
          state_d   = ST_BOUNCE_OUT;
          contact_d = lfsr[0];
          bnc_d     = B_LAST;
          stp_d     = S_LAST;
        end else begin
          hg_d = hg_q - CW'(1);
        end
      end

      ST_GAP: begin
        if (hg_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          hg_d = hg_q - CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Release path shared by normal completion and abort; a zero gap
    // finishes straight away.
    if (release_now) begin
      contact_d = 1'b0;
      if (NO_GAP) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_GAP;
        hg_d    = G_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      contact_q <= 1'b0;
      key_row_q <= '0;
      key_col_q <= '0;
      hold_q    <= '0;
      bnc_q     <= '0;
      stp_q     <= '0;
      hg_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      contact_q <= contact_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      hold_q    <= hold_d;
      bnc_q     <= bnc_d;
      stp_q     <= stp_d;
      hg_q      <= hg_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
    end
  end

  // Row drive is combinational from the column strobes, as a real membrane is.
  always_comb begin
    fil = FIL_IDLE;
    if (contact_q && !col[key_col_q]) fil[key_row_q] = 1'b0;
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/teclado_emulador.md
# teclado_emulador

Responder side of the 4x4 matrix-keypad interface: given a key press command, it drives the row lines `fil` in response to the column strobes `col` from the keypad scanner, exactly as a passive membrane keypad would. It adds deterministic contact bounce on press and release. It replaces the physical keypad in simulation and serves as an on-board self-test source, feeding the scanner/debounce chain unchanged.

## Interface
- `BOUNCE_CYCLES`, 270_000: length of each bounce window (press and release); 0 disables bounce.
- `BOUNCE_STEP`, 2_700: cycles between contact re-samples inside a bounce window; must be ≥ 1.
- `RELEASE_GAP`, 27_000: cycles after release bounce before `done` / next command.
- `HOLD_W`, 25: width of `cmd_hold`.
- `LFSR_SEED`, 16'hACE1: bounce LFSR reset value; must be nonzero.
- `clk` input 1: system clock (27 MHz).
- `rst` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: press command offered.
- `cmd_ready` output 1: emulator can accept a command (IDLE only).
- `cmd_row` input 2: row index 0..3 of the key.
- `cmd_col` input 2: column index 0..3 of the key.
- `cmd_hold` input HOLD_W: stable-closed duration in cycles; 0 is treated as 1.
- `cmd_abort` input 1: force immediate release.
- `col` input 4: column strobes from scanner, active-low.
- `fil` output 4: row lines to debounce/scanner, active-low, idle 4'b1111.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE:
  - `cmd_ready`=1 and `busy`=0.
  - On `cmd_valid`: latch row, col and hold (0→1), then go to BOUNCE_IN. If `BOUNCE_CYCLES`=0, go straight to HOLD.
- BOUNCE_IN:
  - Runs for `BOUNCE_CYCLES` cycles.
  - Every `BOUNCE_STEP` cycles, starting with the first cycle of the state, `contact` ← LFSR bit 0.
  - On exit, `contact` ← 1 and the state moves to HOLD.
- HOLD: `contact`=1 for exactly the latched hold count, then BOUNCE_OUT (or GAP if `BOUNCE_CYCLES`=0).
- BOUNCE_OUT: same sampling rule as BOUNCE_IN; on exit `contact` ← 0 and the state moves to GAP.
- GAP:
  - `contact`=0 for `RELEASE_GAP` cycles.
  - Then return to IDLE with `done`=1 for that single cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in any state, is never reloaded except by reset, and never reaches zero.
- Row drive: `fil[r]` = 0 iff `contact`=1 and r = latched row and `col[latched col]`=0; all other bits are 1.
  - Combinational path from `col` to `fil`; `contact` and the latched key are registered.
  - Several columns low at once: the rule above still applies; only the latched row can go low.
  - `col`=4'b1111: `fil`=4'b1111.
- `cmd_abort`:
  - In BOUNCE_IN, HOLD or BOUNCE_OUT: `contact` ← 0 on the next edge and the state moves to GAP; `done` still pulses at the end of GAP.
  - Ignored in IDLE and GAP. In IDLE with `cmd_valid` in the same cycle, the command is accepted.
- `cmd_valid` while not in IDLE: ignored, not queued, because `cmd_ready`=0.
- Async reset mid-sequence: everything returns to reset values immediately and `fil` goes to 4'b1111 in the same cycle.

## Timing
- Reset values: state IDLE, `contact`=0, `fil`=4'b1111, `cmd_ready`=1, `busy`=0, `done`=0, LFSR=`LFSR_SEED`, all counters 0.
- Handshake: a command is accepted on a rising edge with `cmd_valid`&&`cmd_ready`. `cmd_ready` drops to 0 on the following cycle.
- Sequence latency: acceptance edge + 2·`BOUNCE_CYCLES` + hold + `RELEASE_GAP` cycles, then `done` asserts. A new command can be accepted on the `done` cycle.
- First possible `fil` low: the cycle after acceptance when BOUNCE_CYCLES=0; otherwise within BOUNCE_IN, subject to the LFSR.
- `busy` = (state ≠ IDLE), registered.

## Structure
- Package `teclado_pkg`:
  - State enum `emu_state_t`.
  - Constant `FIL_IDLE`=4'b1111.
  - LFSR tap mask.
- Sub-module `lfsr16`: `clk`, `rst`, `seed` parameter, 16-bit `q`, free-running.
- Remainder is one FSM with three down-counters: bounce, step, and a hold/gap counter shared between HOLD and GAP.

## Test plan
- BOUNCE_CYCLES=0, RELEASE_GAP=4, key (row 2, col 1), hold=10, `col` cycling 1110,1101,1011,0111:
  - `fil`=4'b1011 only while `col`=4'b1101 during the 10 HOLD cycles, otherwise 1111.
  - `done` asserts exactly 14 cycles after acceptance.
- BOUNCE_CYCLES=40, BOUNCE_STEP=4, `col` held at 4'b1110, key (0, 0), hold=20:
  - `fil[0]` toggles only on 4-cycle boundaries inside the two 40-cycle windows.
  - `fil[0]` is solidly 0 for 20 cycles between them.
  - Sequence is bit-identical across two runs from reset.
- `cmd_abort` pulsed on the 5th HOLD cycle: `fil`=4'b1111 on the next cycle, then `done` after RELEASE_GAP.
- `cmd_valid` held high during a sequence:
  - No second acceptance until `done`.
  - A second command is accepted on the `done` cycle.
  - `cmd_hold`=0 produces a single HOLD cycle.
- Reset asserted during HOLD: `fil`=4'b1111, `busy`=0, `cmd_ready`=1 immediately.
- Full chain (emulator → debounce → scanner) with keys 4, 2, '#', 2, '#': the design displays the division of 42 by 2.
